fetch_sequencer: RTL and testbench

- Instruction-issue side of the opcode interface: fetches 32-bit instructions from instruction memory over a req/ack handshake.
- Presents each instruction (with its opcode field, bits [31:26]) to the decode/control stage through a valid/ready handshake.
- Holds the program counter and applies jump/branch redirects computed downstream from the decoded jmpSel/lblSel.
- Stops issuing when a HALT opcode is consumed.

---
 rtl/fetch_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_fetch_sequencer.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : fetch_sequencer
// Description : Instruction-issue front end. Fetches 32-bit instruction words
//               from instruction memory over a req/ack handshake, holds each
//               word for the decode stage behind a valid/ready handshake,
//               keeps the program counter, applies downstream jump/branch
//               redirects and stops for good once a HALT opcode is consumed.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   enable       in   permit new fetches (never aborts work in flight)
//   imemReq      out  fetch request to instruction memory
//   imemAddr     out  fetch address, stable while imemReq is high
//   imemAck      in   memory returns data this cycle (ignored when no request)
//   imemData     in   instruction word, valid with imemAck
//   instr        out  instruction held for the decode stage
//   opcode       out  instr[31:26], combinational
//   instrPc      out  address of instr
//   instrValid   out  instr/opcode/instrPc valid
//   instrReady   in   decode stage accepts instr this cycle
//   redirect     in   load redirectAddr as the next fetch address
//   redirectAddr in   jump/branch target, used unmodified
//   halted       out  HALT opcode consumed, fetching stopped until reset
// ============================================================================
module fetch_sequencer #(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int unsigned       PC_STEP  = 4,
  parameter logic [5:0]        HALT_OP  = 6'b111111
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  output logic              imemReq,
  output logic [ADDR_W-1:0] imemAddr,
  input  logic              imemAck,
  input  logic [31:0]       imemData,
  output logic [31:0]       instr,
  output logic [5:0]        opcode,
  output logic [ADDR_W-1:0] instrPc,
  output logic              instrValid,
  input  logic              instrReady,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirectAddr,
  output logic              halted
);

  // --------------------------------------------------------------------------
  // State encoding
  //   IDLE  : nothing outstanding, waiting for enable
  //   REQ   : request at imemAddr outstanding, its data will be kept
  //   DRAIN : request outstanding but a redirect arrived; data will be dropped
  //   HOLD  : instruction presented to decode, waiting for instrReady
  //   HALT  : HALT opcode consumed, only reset leaves
  // --------------------------------------------------------------------------
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_HALT  = 3'd4;

  localparam logic [ADDR_W-1:0] c_pc_step = ADDR_W'(PC_STEP);

  logic [2:0]        state_q,    state_d;
  logic [ADDR_W-1:0] pc_q,       pc_d;
  logic              req_q,      req_d;
  logic [ADDR_W-1:0] addr_q,     addr_d;
  logic [31:0]       instr_q,    instr_d;
  logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
  logic              valid_q,    valid_d;
  logic              halted_q,   halted_d;

  logic              w_is_halt;
  logic              w_capture;
  logic              w_launch;
  logic [ADDR_W-1:0] w_fetch_addr;
  logic [ADDR_W-1:0] w_pc_inc;

  // The held instruction is a HALT; only meaningful in HOLD.
  assign w_is_halt = (instr_q[31:26] == HALT_OP);

  // Returned data is kept only for a live (non-draining) request that is not
  // being redirected in the same cycle.
  assign w_capture = (state_q == S_REQ) && imemAck && !redirect;

  // Any request launched this cycle uses the newest target: a same-cycle
  // redirect beats the stored pc.
  assign w_fetch_addr = redirect ? redirectAddr : pc_q;

  // Wraps modulo 2^ADDR_W by construction.
  assign w_pc_inc = pc_q + c_pc_step;

  // --------------------------------------------------------------------------
  // State / datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      req_q      <= 1'b0;
      addr_q     <= RESET_PC;
      instr_q    <= '0;
      instr_pc_q <= '0;
      valid_q    <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      valid_q    <= valid_d;
      halted_q   <= halted_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (enable) state_d = S_REQ;
      end
      S_REQ: begin
        // A redirect coinciding with ack drops the data and immediately
        // issues a fresh request; without ack the old request must finish.
        if (imemAck) state_d = redirect ? S_REQ : S_HOLD;
        else if (redirect) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (imemAck) state_d = S_REQ;
      end
      S_HOLD: begin
        // A consumed HALT wins even over a simultaneous redirect.
        if (instrReady && w_is_halt) state_d = S_HALT;
        else if (redirect)           state_d = S_REQ;
        else if (instrReady)         state_d = enable ? S_REQ : S_IDLE;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Output / datapath next values
  // --------------------------------------------------------------------------
  always_comb begin
    // A new request starts when REQ is entered from elsewhere, or when REQ
    // re-issues after an ack (the redirect-with-ack case).
    w_launch   = (state_d == S_REQ) && ((state_q != S_REQ) || imemAck);

    req_d      = (state_d == S_REQ) || (state_d == S_DRAIN);
    addr_d     = w_launch ? w_fetch_addr : addr_q;
    valid_d    = (state_d == S_HOLD);
    halted_d   = (state_d == S_HALT);

    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    if (w_capture) begin
      instr_d    = imemData;
      instr_pc_d = addr_q;
    end

    // Redirect has the final say over pc in every state, HALT included.
    pc_d = pc_q;
    if (redirect)       pc_d = redirectAddr;
    else if (w_capture) pc_d = w_pc_inc;
  end

  assign imemReq    = req_q;
  assign imemAddr   = addr_q;
  assign instr      = instr_q;
  assign opcode     = instr_q[31:26];
  assign instrPc    = instr_pc_q;
  assign instrValid = valid_q;
  assign halted     = halted_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_sequencer
// Description : Directed self-checking bench for fetch_sequencer. A behavioural
//               instruction memory with programmable latency answers requests;
//               expected fetch addresses and expected issued instructions are
//               queued as stimulus is planned and compared when the DUT
//               produces them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_sequencer;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemAck;
  logic [31:0] imemData;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic [31:0] instrPc;
  logic        instrValid;
  logic        instrReady;
  logic        redirect;
  logic [31:0] redirectAddr;
  logic        halted;

  int          n_total = 0;
  int          n_pass  = 0;
  int          tick_no = 0;
  int          acc_cnt = 0;
  int          acc_ticks[$];
  exp_t        exp_q[$];
  logic [31:0] exp_addr_q[$];

  // memory model state
  int          mem_lat   = 1;
  logic        spur      = 1'b0;
  logic [31:0] halt_addr = 32'hFFFF_FFF0;
  int          m_cnt     = 0;
  logic        m_prev_req  = 1'b0;
  logic        m_prev_ack  = 1'b0;
  logic [31:0] m_prev_addr = '0;
  logic        req_seen    = 1'b0;

  always #5 clk = ~clk;

  fetch_sequencer #(
    .ADDR_W   (32),
    .RESET_PC (32'h0),
    .PC_STEP  (4),
    .HALT_OP  (6'b111111)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .imemReq      (imemReq),
    .imemAddr     (imemAddr),
    .imemAck      (imemAck),
    .imemData     (imemData),
    .instr        (instr),
    .opcode       (opcode),
    .instrPc      (instrPc),
    .instrValid   (instrValid),
    .instrReady   (instrReady),
    .redirect     (redirect),
    .redirectAddr (redirectAddr),
    .halted       (halted)
  );

  // Memory contents: opcode never equals 6'h3F except at halt_addr.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == halt_addr) return 32'hFC00_0000;
    return {1'b0, a[6:2], a[25:0]};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic push_instr(input logic [31:0] pc);
    exp_t e;
    e.pc  = pc;
    e.ins = mem_word(pc);
    exp_q.push_back(e);
  endtask

  // One clock cycle: sample at the falling edge (monitor + memory response),
  // then return 1 time unit after the rising edge.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    tick_no++;
    if (imemReq) req_seen = 1'b1;

    if (instrValid && instrReady) begin
      acc_cnt++;
      acc_ticks.push_back(tick_no);
      if (exp_q.size() == 0) begin
        check("unexpected_instr", {63'b0, instrValid}, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("instr_pc", {32'b0, instrPc}, {32'b0, e.pc});
        check("instr",    {32'b0, instr},   {32'b0, e.ins});
        check("opcode",   {58'b0, opcode},  {58'b0, e.ins[31:26]});
      end
    end

    if (imemReq) begin
      if (m_prev_req && (imemAddr == m_prev_addr) && !m_prev_ack) begin
        m_cnt++;
      end else begin
        m_cnt = 1;
        if (exp_addr_q.size() == 0)
          check("unexpected_req", {63'b0, imemReq}, 64'd0);
        else
          check("req_addr", {32'b0, imemAddr}, {32'b0, exp_addr_q.pop_front()});
      end
      imemAck  = (m_cnt >= mem_lat);
      imemData = imemAck ? mem_word(imemAddr) : 32'hDEAD_BEEF;
    end else begin
      m_cnt    = 0;
      imemAck  = spur;
      imemData = 32'hDEAD_BEEF;
    end
    m_prev_req  = imemReq;
    m_prev_addr = imemAddr;
    m_prev_ack  = imemReq && imemAck;

    @(posedge clk);
    #1;
  endtask

  task automatic wait_acc(input int target, input int budget);
    int b;
    b = budget;
    while (acc_cnt < target && b > 0) begin
      tick();
      b--;
    end
    if (acc_cnt < target) check("wait_accept_timeout", acc_cnt, target);
  endtask

  initial begin
    rst_n        = 1'b1;
    enable       = 1'b0;
    instrReady   = 1'b0;
    redirect     = 1'b0;
    redirectAddr = '0;
    imemAck      = 1'b0;
    imemData     = '0;
    #1 rst_n = 1'b0;
    #1;

    // ---- reset state
    check("rst_imemReq",    {63'b0, imemReq},    64'd0);
    check("rst_imemAddr",   {32'b0, imemAddr},   64'd0);
    check("rst_instr",      {32'b0, instr},      64'd0);
    check("rst_instrPc",    {32'b0, instrPc},    64'd0);
    check("rst_instrValid", {63'b0, instrValid}, 64'd0);
    check("rst_halted",     {63'b0, halted},     64'd0);
    check("rst_opcode",     {58'b0, opcode},     64'd0);

    repeat (2) @(posedge clk);
    #1;

    // ---- 1: sequential fetch, 1-cycle memory, decode always ready
    exp_addr_q.push_back(32'h0);
    exp_addr_q.push_back(32'h4);
    exp_addr_q.push_back(32'h8);
    exp_addr_q.push_back(32'hC);
    push_instr(32'h0);
    push_instr(32'h4);
    push_instr(32'h8);
    rst_n      = 1'b1;
    enable     = 1'b1;
    instrReady = 1'b1;
    mem_lat    = 1;
    wait_acc(3, 20);
    if (acc_ticks.size() >= 3) begin
      check("throughput_gap1", acc_ticks[1] - acc_ticks[0], 2);
      check("throughput_gap2", acc_ticks[2] - acc_ticks[1], 2);
    end

    // ---- 2: backpressure in HOLD for 5 cycles
    instrReady = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_stable", {instrValid, imemReq, instrPc, instr},
            {1'b1, 1'b0, 32'hC, mem_word(32'hC)});
    end
    mem_lat = 3;
    exp_addr_q.push_back(32'h10);
    push_instr(32'hC);
    instrReady = 1'b1;
    tick();
    check("after_hold_req", {imemReq, imemAddr}, {1'b1, 32'h10});

    // ---- 3: redirect while REQ waits 3 cycles for ack
    redirect     = 1'b1;
    redirectAddr = 32'h100;
    tick();
    redirect = 1'b0;
    check("drain_addr1", {imemReq, imemAddr}, {1'b1, 32'h10});
    tick();
    check("drain_addr2", {imemReq, imemAddr}, {1'b1, 32'h10});
    exp_addr_q.push_back(32'h100);
    tick();
    check("post_drain", {instrValid, imemReq, imemAddr}, {1'b0, 1'b1, 32'h100});
    mem_lat = 1;
    push_instr(32'h100);
    exp_addr_q.push_back(32'h104);
    tick();
    tick();

    // ---- 4: redirect coinciding with ack, then redirect in HOLD
    redirect     = 1'b1;
    redirectAddr = 32'h40;
    exp_addr_q.push_back(32'h40);
    tick();
    redirect = 1'b0;
    check("ack_redirect", {instrValid, imemReq, imemAddr}, {1'b0, 1'b1, 32'h40});
    instrReady = 1'b0;
    tick();
    check("hold_0x40", {instrValid, instrPc}, {1'b1, 32'h40});
    redirect     = 1'b1;
    redirectAddr = 32'h200;
    exp_addr_q.push_back(32'h200);
    tick();
    redirect = 1'b0;
    check("hold_redirect", {instrValid, imemReq, imemAddr}, {1'b0, 1'b1, 32'h200});

    // ---- 5: HALT
    halt_addr  = 32'h200;
    instrReady = 1'b1;
    push_instr(32'h200);
    tick();
    check("halt_opcode", {58'b0, opcode}, 64'h3F);
    tick();
    check("halted", {halted, instrValid, imemReq}, {1'b1, 1'b0, 1'b0});
    req_seen     = 1'b0;
    spur         = 1'b1;
    redirect     = 1'b1;
    redirectAddr = 32'h300;
    tick();
    redirect = 1'b0;
    repeat (19) tick();
    check("halt_sticky", {req_seen, halted, instrValid}, {1'b0, 1'b1, 1'b0});
    spur  = 1'b0;
    rst_n = 1'b0;
    #1;
    check("halt_reset", {halted, imemReq, imemAddr}, {1'b0, 1'b0, 32'h0});
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_addr_q.push_back(32'h0);
    tick();
    check("restart_pc", {imemReq, imemAddr}, {1'b1, 32'h0});

    // ---- 6: wrap-around and asynchronous reset mid-request
    redirect     = 1'b1;
    redirectAddr = 32'hFFFF_FFFC;
    exp_addr_q.push_back(32'hFFFF_FFFC);
    tick();
    redirect = 1'b0;
    push_instr(32'hFFFF_FFFC);
    tick();
    tick();
    check("wrap_addr", {imemReq, imemAddr}, {1'b1, 32'h0});
    rst_n = 1'b0;
    #1;
    check("async_rst_req", {63'b0, imemReq}, 64'd0);

    check("instr_queue_drained", exp_q.size(), 0);
    check("addr_queue_drained",  exp_addr_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
